// File: rtl/nios2_qsys_key_debounce_pkg.sv
// Shared defaults and channel state encoding for the key debouncer.
package nios2_qsys_key_debounce_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_CNT_W           = 20;

  typedef enum logic {
    ST_REL = 1'b0,
    ST_PRS = 1'b1
  } key_state_e;

  // Raw pin level of a released key for the given board polarity.
  function automatic logic idle_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/nios2_qsys_key_debounce_ch.sv
// One key channel: two-flop synchroniser, stability counter and
// press/release pulse generation. All outputs come straight from flops.
module nios2_qsys_key_debounce_ch
  import nios2_qsys_key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic             LP_IDLE    = idle_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  key_state_e       r_state;
  logic             r_press;
  logic             r_release;
  logic             w_pressed;

  assign w_pressed = r_s2 ^ LP_IDLE;

  // Synchronise the pin, then require DEBOUNCE_CYCLES consecutive mismatching
  // samples before flipping state; any agreeing sample restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1      <= LP_IDLE;
      r_s2      <= LP_IDLE;
      r_cnt     <= '0;
      r_state   <= ST_REL;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= i_key_raw;
      r_s2      <= r_s1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_REL: begin
          if (!w_pressed) begin
            r_cnt <= '0;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_cnt   <= '0;
            r_state <= ST_PRS;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PRS: begin
          if (w_pressed) begin
            r_cnt <= '0;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_cnt     <= '0;
            r_state   <= ST_REL;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_REL;
        end
      endcase
    end
  end

  assign o_level   = (r_state == ST_PRS);
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/nios2_qsys_key_debounce.sv
// Debounces WIDTH raw push-buttons into active-high levels for the key PIO,
// plus one-cycle press/release pulses. Channels are fully independent.
module nios2_qsys_key_debounce
  import nios2_qsys_key_debounce_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] w_release;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    nios2_qsys_key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .i_clk     (clk),
      .i_rst_n   (reset_n),
      .i_key_raw (key_raw[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  assign key_level   = w_level;
  assign key_press   = w_press;
  assign key_release = w_release;

endmodule

// File: tb/tb_nios2_qsys_key_debounce.sv
// Bench for nios2_qsys_key_debounce with DEBOUNCE_CYCLES=4: vector table plus
// scoreboard for the active-low instance, hand sequences for reset and polarity.
module tb_nios2_qsys_key_debounce;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] raw1, lvl1, prs1, rel1;
  logic [7:0] raw0, lvl0, prs0, rel0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  nios2_qsys_key_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .reset_n(reset_n), .key_raw(raw1),
    .key_level(lvl1), .key_press(prs1), .key_release(rel1)
  );

  nios2_qsys_key_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(0)) u_dut_ah (
    .clk(clk), .reset_n(reset_n), .key_raw(raw0),
    .key_level(lvl0), .key_press(prs0), .key_release(rel0)
  );

  typedef struct {
    logic [7:0] raw;
    logic [7:0] lvl;
    logic [7:0] prs;
    logic [7:0] rel;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] lvl;
    logic [7:0] prs;
    logic [7:0] rel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [7:0] l, input logic [7:0] p,
                      input logic [7:0] r);
    chk({name, " level"},   lvl1, l);
    chk({name, " press"},   prs1, p);
    chk({name, " release"}, rel1, r);
  endtask

  // Row i's expectation is what the outputs show three cycles after row i is
  // driven: a level is accepted on the row that completes 4 equal raw rows.
  task automatic add(input int n, input logic [7:0] raw, input logic [7:0] l,
                     input logic [7:0] p, input logic [7:0] r);
    vec_t v;
    v.raw = raw; v.lvl = l; v.prs = p; v.rel = r;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb.pop_front();
    chk3($sformatf("row%0d", e.idx), e.lvl, e.prs, e.rel);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0;
    raw1    = 8'hFF;
    raw0    = 8'h00;

    // Reset state and quiet period after release.
    repeat (5) tick();
    chk3("in_reset", 8'h00, 8'h00, 8'h00);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk3($sformatf("post_reset%0d", c), 8'h00, 8'h00, 8'h00);
      chk("post_reset al0 level", lvl0 | prs0 | rel0, 8'h00);
    end

    // Clean press/release of key 0.
    add(4, 8'hFF, 8'h00, 8'h00, 8'h00);
    add(3, 8'hFE, 8'h00, 8'h00, 8'h00);
    add(1, 8'hFE, 8'h01, 8'h01, 8'h00);
    add(3, 8'hFE, 8'h01, 8'h00, 8'h00);
    add(3, 8'hFF, 8'h01, 8'h00, 8'h00);
    add(1, 8'hFF, 8'h00, 8'h00, 8'h01);
    add(3, 8'hFF, 8'h00, 8'h00, 8'h00);
    // Bounce on key 3: never four equal rows, then bounce ending pressed.
    for (int j = 0; j < 4; j++) begin
      add(2, 8'hF7, 8'h00, 8'h00, 8'h00);
      add(2, 8'hFF, 8'h00, 8'h00, 8'h00);
    end
    add(2, 8'hFF, 8'h00, 8'h00, 8'h00);
    for (int j = 0; j < 2; j++) begin
      add(2, 8'hF7, 8'h00, 8'h00, 8'h00);
      add(2, 8'hFF, 8'h00, 8'h00, 8'h00);
    end
    add(3, 8'hF7, 8'h00, 8'h00, 8'h00);
    add(1, 8'hF7, 8'h08, 8'h08, 8'h00);
    add(2, 8'hF7, 8'h08, 8'h00, 8'h00);
    add(3, 8'hFF, 8'h08, 8'h00, 8'h00);
    add(1, 8'hFF, 8'h00, 8'h00, 8'h08);
    add(3, 8'hFF, 8'h00, 8'h00, 8'h00);
    // Threshold glitches on key 1: 3 samples rejected, 4 accepted.
    add(3, 8'hFD, 8'h00, 8'h00, 8'h00);
    add(4, 8'hFF, 8'h00, 8'h00, 8'h00);
    add(3, 8'hFD, 8'h00, 8'h00, 8'h00);
    add(1, 8'hFD, 8'h02, 8'h02, 8'h00);
    add(3, 8'hFF, 8'h02, 8'h00, 8'h00);
    add(1, 8'hFF, 8'h00, 8'h00, 8'h02);
    add(3, 8'hFF, 8'h00, 8'h00, 8'h00);
    // Multi-key press, then staggered releases one cycle apart.
    add(3, 8'h5A, 8'h00, 8'h00, 8'h00);
    add(1, 8'h5A, 8'hA5, 8'hA5, 8'h00);
    add(2, 8'h5A, 8'hA5, 8'h00, 8'h00);
    add(1, 8'h5B, 8'hA5, 8'h00, 8'h00);
    add(1, 8'h5F, 8'hA5, 8'h00, 8'h00);
    add(1, 8'h7F, 8'hA5, 8'h00, 8'h00);
    add(1, 8'hFF, 8'hA4, 8'h00, 8'h01);
    add(1, 8'hFF, 8'hA0, 8'h00, 8'h04);
    add(1, 8'hFF, 8'h80, 8'h00, 8'h20);
    add(1, 8'hFF, 8'h00, 8'h00, 8'h80);
    add(3, 8'hFF, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      if (sb.size() == 3) pop_cmp();
      raw1  = vecs[i].raw;
      e.idx = i; e.lvl = vecs[i].lvl; e.prs = vecs[i].prs; e.rel = vecs[i].rel;
      sb.push_back(e);
    end
    for (int d = 0; d < 3; d++) begin
      tick();
      pop_cmp();
    end

    // Reset mid-count with the key still held, then fresh acceptance.
    raw1 = 8'hFE;
    repeat (6) tick();
    chk3("held_accept", 8'h01, 8'h01, 8'h00);
    raw1 = 8'hFF;
    repeat (3) tick();
    chk("pre_reset level", lvl1, 8'h01);
    raw1    = 8'hFE;
    reset_n = 1'b0;
    #1;
    chk3("async_reset", 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk3($sformatf("fresh_wait%0d", c), 8'h00, 8'h00, 8'h00);
    end
    tick();
    chk3("fresh_press", 8'h01, 8'h01, 8'h00);
    tick();
    chk3("fresh_after", 8'h01, 8'h00, 8'h00);

    // Active-high instance: raw bit 7 high is a press.
    raw0 = 8'h80;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("ah_wait%0d level", c), lvl0, 8'h00);
      chk($sformatf("ah_wait%0d pulses", c), prs0 | rel0, 8'h00);
    end
    tick();
    chk("ah_press level", lvl0, 8'h80);
    chk("ah_press pulse", prs0, 8'h80);
    chk("ah_press release", rel0, 8'h00);
    tick();
    chk("ah_after level", lvl0, 8'h80);
    chk("ah_after pulse", prs0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
